// File: rtl/passcode_pkg.sv
// Shared constants for the passcode display path: segment glyphs (abcdefg,
// active-high), slot count and the BCD-to-glyph lookup.
package passcode_pkg;

  localparam int NUM_SLOTS = 8;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_O     = 7'b1111110;
  localparam logic [6:0] SEG_P     = 7'b1100111;
  localparam logic [6:0] SEG_n     = 7'b0010101;

  // BCD digit to glyph; non-decimal nibbles show the error glyph.
  function automatic logic [6:0] bcd_glyph(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'd0:    glyph = 7'b1111110;
      4'd1:    glyph = 7'b0110000;
      4'd2:    glyph = 7'b1101101;
      4'd3:    glyph = 7'b1111001;
      4'd4:    glyph = 7'b0110011;
      4'd5:    glyph = 7'b1011011;
      4'd6:    glyph = 7'b1011111;
      4'd7:    glyph = 7'b1110000;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1111011;
      default: glyph = SEG_E;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg_pattern_sel.sv
// Combinational glyph selection for the slot currently being scanned.
// Priority: alarm blink, unlocked banner, unused slot, masked entry, digit.
module seg_pattern_sel
  import passcode_pkg::*;
(
  input  logic [2:0]  slot,
  input  logic [31:0] digits_flat,
  input  logic [3:0]  digit_count,
  input  logic        mask_en,
  input  logic        unlocked,
  input  logic        alarm,
  input  logic        blink_on,
  output logic [6:0]  seg
);

  // Slot 0 is the first entered digit and lives in the top nibble.
  logic [3:0] nibble_arr [NUM_SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_nibble
      assign nibble_arr[gi] = digits_flat[4*(NUM_SLOTS-gi)-1 -: 4];
    end
  endgenerate

  // Counts above eight are clamped so every slot is shown.
  logic [3:0] eff_count;
  assign eff_count = (digit_count > 4'd8) ? 4'd8 : digit_count;

  // Glyph priority chain for the current slot.
  always_comb begin
    seg = SEG_BLANK;
    if (alarm) begin
      seg = blink_on ? SEG_DASH : SEG_BLANK;
    end else if (unlocked) begin
      case (slot)
        3'd0:    seg = SEG_O;
        3'd1:    seg = SEG_P;
        3'd2:    seg = SEG_E;
        3'd3:    seg = SEG_n;
        default: seg = SEG_BLANK;
      endcase
    end else if ({1'b0, slot} >= eff_count) begin
      seg = SEG_BLANK;
    end else if (mask_en) begin
      seg = SEG_DASH;
    end else begin
      seg = bcd_glyph(nibble_arr[slot]);
    end
  end

endmodule

// File: rtl/passcode_display_scanner.sv
// Time-multiplexed 8-digit 7-segment scanner for the passcode store.
// Each slot is lit CLK_DIV-1 cycles followed by one blank cycle so the
// segment bus never drives the wrong digit while the anode switches.
module passcode_display_scanner
  import passcode_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digits_flat,
  input  logic [3:0]  digit_count,
  input  logic        mask_en,
  input  logic        unlocked,
  input  logic        alarm,
  output logic [6:0]  seg_out,
  output logic [7:0]  an,
  output logic        frame_tick
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] prescaler_reg;
  logic [2:0]    slot_reg;
  logic [FW-1:0] frame_cnt_reg;
  logic          blink_on_reg;
  logic [7:0]    an_reg;
  logic [6:0]    seg_reg;
  logic          frame_tick_reg;

  logic          tc;
  logic          frame_wrap;
  logic [7:0]    slot_onehot;
  logic [6:0]    seg_next;

  assign tc         = (prescaler_reg == PW'(CLK_DIV - 1));
  assign frame_wrap = tc && (slot_reg == 3'd7);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_onehot
      assign slot_onehot[gi] = (slot_reg == 3'(gi));
    end
  endgenerate

  seg_pattern_sel u_seg_pattern_sel (
    .slot        (slot_reg),
    .digits_flat (digits_flat),
    .digit_count (digit_count),
    .mask_en     (mask_en),
    .unlocked    (unlocked),
    .alarm       (alarm),
    .blink_on    (blink_on_reg),
    .seg         (seg_next)
  );

  // Prescaler and slot counter: advance one slot per CLK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_reg <= '0;
      slot_reg      <= 3'd0;
    end else if (tc) begin
      prescaler_reg <= '0;
      slot_reg      <= slot_reg + 3'd1;
    end else begin
      prescaler_reg <= prescaler_reg + 1'b1;
    end
  end

  // Blink timer: counts frame wraps while alarmed; toggles every BLINK_FRAMES.
  // It advances on the same edge that raises frame_tick, which is a blank
  // cycle, so the new blink phase starts cleanly on slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
    end else if (!alarm) begin
      frame_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
    end else if (frame_wrap) begin
      if (frame_cnt_reg == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_reg <= '0;
        blink_on_reg  <= ~blink_on_reg;
      end else begin
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end
    end
  end

  // Output registers: blank on the terminal cycle of each slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg         <= 8'h00;
      seg_reg        <= SEG_BLANK;
      frame_tick_reg <= 1'b0;
    end else begin
      an_reg         <= tc ? 8'h00 : slot_onehot;
      seg_reg        <= tc ? SEG_BLANK : seg_next;
      frame_tick_reg <= frame_wrap;
    end
  end

  assign an         = an_reg;
  assign seg_out    = seg_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_passcode_display_scanner.sv
// Bench for passcode_display_scanner: a cycle-level model derived from the
// scan timing rules (edge count since reset -> slot/phase), directed glyph
// checks with literal values, then randomized input traffic.
module tb_passcode_display_scanner;

  localparam int D = 4;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] digits_flat = 32'h0;
  logic [3:0]  digit_count = 4'd0;
  logic        mask_en = 1'b0;
  logic        unlocked = 1'b0;
  logic        alarm = 1'b0;
  logic [6:0]  seg_out;
  logic [7:0]  an;
  logic        frame_tick;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  passcode_display_scanner #(.CLK_DIV(D), .BLINK_FRAMES(B)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits_flat (digits_flat),
    .digit_count (digit_count),
    .mask_en     (mask_en),
    .unlocked    (unlocked),
    .alarm       (alarm),
    .seg_out     (seg_out),
    .an          (an),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h want %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting, got none want event", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;
      3: return 7'b1111001;  4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;  8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b1001111;
    endcase
  endfunction

  function automatic logic [6:0] exp_pattern(input int slot, input logic [31:0] d, input int cnt,
                                             input bit m, input bit u, input bit a, input bit blink);
    int lim;
    if (a) return blink ? 7'b0000001 : 7'b0000000;
    if (u) begin
      case (slot)
        0: return 7'b1111110;
        1: return 7'b1100111;
        2: return 7'b1001111;
        3: return 7'b0010101;
        default: return 7'b0000000;
      endcase
    end
    lim = (cnt > 8) ? 8 : cnt;
    if (slot >= lim) return 7'b0000000;
    if (m) return 7'b0000001;
    return glyph(int'((d >> (28 - 4 * slot)) & 32'hF));
  endfunction

  // Edges since reset n: the state before edge n+1 has phase n%D and slot (n/D)%8.
  function automatic bit m_tc(input int n);
    return (n % D) == D - 1;
  endfunction
  function automatic int m_slot(input int n);
    return (n / D) % 8;
  endfunction
  function automatic bit m_wrap(input int n);
    return m_tc(n) && m_slot(n) == 7;
  endfunction

  int         m_n;
  int         m_ticks;
  logic [7:0] m_an;
  logic [6:0] m_seg;
  logic       m_ft;
  logic       m_blink;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n     <= 0;
      m_ticks <= 0;
      m_an    <= 8'h00;
      m_seg   <= 7'h00;
      m_ft    <= 1'b0;
      m_blink <= 1'b1;
    end else begin
      m_seg   <= m_tc(m_n) ? 7'h00 :
                 exp_pattern(m_slot(m_n), digits_flat, int'(digit_count), mask_en, unlocked, alarm, m_blink);
      m_an    <= m_tc(m_n) ? 8'h00 : 8'(8'h01 << m_slot(m_n));
      m_ft    <= m_wrap(m_n);
      m_ticks <= alarm ? m_ticks + (m_wrap(m_n) ? 1 : 0) : 0;
      m_blink <= alarm ? ((((m_ticks + (m_wrap(m_n) ? 1 : 0)) / B) % 2) == 0) : 1'b1;
      m_n     <= m_n + 1;
    end
  end

  // Every-cycle comparison against the model while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_an", 32'(an), 32'(m_an));
      check("model_seg", 32'(seg_out), 32'(m_seg));
      check("model_ftick", 32'(frame_tick), 32'(m_ft));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_slot(input int s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (an == 8'(8'h01 << s)) ok = 1'b1;
    end
  endtask

  task automatic expect_seg(input int s, input logic [6:0] e, input string name);
    bit ok;
    wait_slot(s, ok);
    if (!ok) timeout_fail(name);
    else check(name, 32'(seg_out), 32'(e));
  endtask

  task automatic wait_ft(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (frame_tick) ok = 1'b1;
    end
  endtask

  logic [6:0] dig_tab [8];
  logic [6:0] ban_tab [8];
  logic [7:0] rel_tab [5];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int t0;
    int txn;
    dig_tab = '{7'b1101101, 7'b0110000, 7'b1111011, 7'b1111001,
                7'b1011011, 7'b0110011, 7'b1111111, 7'b1110000};
    ban_tab = '{7'b1111110, 7'b1100111, 7'b1001111, 7'b0010101,
                7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    rel_tab = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h02};

    // Reset state and release timing
    repeat (3) @(negedge clk);
    check("reset_an", 32'(an), 32'h0);
    check("reset_seg", 32'(seg_out), 32'h0);
    check("reset_ftick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("release_an", 32'(an), 32'(rel_tab[i]));
    end
    $display("txn reset release checked");

    // Asynchronous reset mid-slot
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_an", 32'(an), 32'h0);
    check("midreset_seg", 32'(seg_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_an", 32'(an), 32'h01);
    $display("txn mid-slot reset checked");

    // Full 8-digit display
    digits_flat = 32'h21935487;
    digit_count = 4'd8;
    for (int s = 0; s < 8; s++) expect_seg(s, dig_tab[s], "digits8");
    $display("txn digits=%h count=8 checked", digits_flat);

    // Partial count, then masked
    digit_count = 4'd3;
    for (int s = 0; s < 8; s++) expect_seg(s, (s < 3) ? dig_tab[s] : 7'h00, "count3");
    mask_en = 1'b1;
    for (int s = 0; s < 8; s++) expect_seg(s, (s < 3) ? 7'b0000001 : 7'h00, "mask3");
    $display("txn count=3 mask=0/1 checked");

    // Unlocked banner
    unlocked = 1'b1;
    for (int s = 0; s < 8; s++) expect_seg(s, ban_tab[s], "banner");
    $display("txn unlocked banner checked");

    // Alarm over banner: start right after a frame wrap
    wait_ft(ok);
    if (!ok) timeout_fail("alarm_sync");
    alarm = 1'b1;
    @(negedge clk);
    check("alarm_dash_an", 32'(an), 32'h01);
    check("alarm_dash_seg", 32'(seg_out), 32'b0000001);
    wait_ft(ok); if (!ok) timeout_fail("alarm_ft1");
    wait_ft(ok); if (!ok) timeout_fail("alarm_ft2");
    @(negedge clk);
    check("alarm_blank_an", 32'(an), 32'h01);
    check("alarm_blank_seg", 32'(seg_out), 32'h0);
    wait_ft(ok); if (!ok) timeout_fail("alarm_ft3");
    wait_ft(ok); if (!ok) timeout_fail("alarm_ft4");
    @(negedge clk);
    check("alarm_dash2_seg", 32'(seg_out), 32'b0000001);
    alarm = 1'b0;
    @(negedge clk);
    check("alarm_drop_seg", 32'(seg_out), 32'b1111110);
    $display("txn alarm blink and drop checked");

    // Error glyph and over-range count
    unlocked = 1'b0;
    mask_en = 1'b0;
    digits_flat = 32'hA1935487;
    digit_count = 4'd12;
    expect_seg(0, 7'b1001111, "nibbleA");
    expect_seg(7, 7'b1110000, "count12_slot7");
    $display("txn nibble A count=12 checked");

    // Frame tick period
    wait_ft(ok); if (!ok) timeout_fail("ft_period_a");
    t0 = cyc;
    wait_ft(ok); if (!ok) timeout_fail("ft_period_b");
    check("ft_period", 32'(cyc - t0), 32'd32);
    $display("txn frame_tick period checked");

    // Randomized traffic checked by the model
    txn = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        digits_flat = $urandom;
        digit_count = 4'($urandom_range(0, 15));
        mask_en     = 1'($urandom_range(0, 1));
        unlocked    = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 3) == 0) alarm = ~alarm;
        txn++;
        $display("txn %0d: digits=%h count=%0d mask=%b unl=%b alarm=%b",
                 txn, digits_flat, digit_count, mask_en, unlocked, alarm);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
